// File: rtl/wb_imem_loader.sv
// Wishbone slave that loads the core's instruction memory and controls the core reset.
// Build option: define LOADER_READBACK_EN to enable instruction-memory readback through DATA.
module wb_imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned IMEM_AW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               imem_en_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_wdata_o,
    output logic [3:0]         imem_wmask_o,
    input  logic [31:0]        imem_rdata_i,
    output logic               imem_sel_o,
    output logic               core_rst_no
);

    localparam logic [7:0] OffCtrl   = 8'h00;
    localparam logic [7:0] OffAddr   = 8'h04;
    localparam logic [7:0] OffData   = 8'h08;
    localparam logic [7:0] OffStatus = 8'h0C;

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {StIdle, StMwr, StMrd, StMcap, StAck} state_e;
`else
    typedef enum logic [2:0] {StIdle, StMwr, StAck} state_e;
`endif

    state_e state_q, state_d;

    logic [7:0]         off_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [3:0]         sel_q;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic               core_run_q;
    logic               autoinc_q;
    logic [IMEM_AW-1:0] ptr_q;
    logic               wrap_q;
    logic               err_q;
    logic [15:0]        count_q;

    logic        req;
    logic        is_data;
    logic        accept;
    logic [31:0] reg_rdata;

    assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign is_data = (wbs_adr_i[7:0] == OffData);
    assign accept  = (state_q == StIdle) & req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (is_data && !core_run_q && wbs_we_i) begin
                        state_d = StMwr;
`ifdef LOADER_READBACK_EN
                    end else if (is_data && !core_run_q) begin
                        state_d = StMrd;
`endif
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StMwr:   state_d = wbs_cyc_i ? StAck : StIdle;
`ifdef LOADER_READBACK_EN
            StMrd:   state_d = wbs_cyc_i ? StMcap : StIdle;
            StMcap:  state_d = wbs_cyc_i ? StAck : StIdle;
`endif
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (wbs_adr_i[7:0])
            OffCtrl:   reg_rdata = {30'd0, autoinc_q, core_run_q};
            OffAddr:   reg_rdata = 32'(ptr_q);
            OffStatus: reg_rdata = {count_q, 14'd0, err_q, wrap_q};
            default:   reg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == StAck);
        end
    end

    // Request is latched at acceptance; register side effects apply at the ack edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            off_q   <= 8'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
        end else begin
            if (accept) begin
                off_q   <= wbs_adr_i[7:0];
                we_q    <= wbs_we_i;
                wdata_q <= wbs_dat_i;
                sel_q   <= wbs_sel_i;
                dat_q   <= reg_rdata;
            end
`ifdef LOADER_READBACK_EN
            if (state_q == StMcap && wbs_cyc_i) begin
                dat_q <= imem_rdata_i;
            end
`endif
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            core_run_q <= 1'b0;
            autoinc_q  <= 1'b0;
            ptr_q      <= '0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            if (accept && is_data && core_run_q) begin
                err_q <= 1'b1;
            end
            // The write is committed once the strobe is out, even if cyc drops afterwards.
            if (state_q == StMwr) begin
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
                if (autoinc_q) begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        wrap_q <= 1'b1;
                    end
                end
            end
            if (state_q == StAck && we_q) begin
                case (off_q)
                    OffCtrl: begin
                        core_run_q <= wdata_q[0];
                        autoinc_q  <= wdata_q[1];
                    end
                    OffAddr: ptr_q <= wdata_q[IMEM_AW-1:0];
                    OffStatus: begin
                        wrap_q  <= 1'b0;
                        err_q   <= 1'b0;
                        count_q <= 16'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_READBACK_EN
    assign imem_en_o = (state_q == StMwr) | (state_q == StMrd);
`else
    assign imem_en_o = (state_q == StMwr);
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata_i;
`endif
    assign imem_we_o    = (state_q == StMwr);
    assign imem_addr_o  = ptr_q;
    assign imem_wdata_o = wdata_q;
    assign imem_wmask_o = sel_q;
    assign imem_sel_o   = ~core_run_q;
    assign core_rst_no  = core_run_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_imem_loader.sv
// Scoreboard bench for wb_imem_loader: random Wishbone traffic against a behavioural register/memory model.
module tb_wb_imem_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        imem_en, imem_we, imem_sel, core_rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata, imem_rdata;
    logic [3:0]  imem_wmask;

    wb_imem_loader dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .imem_en_o    (imem_en),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .imem_wmask_o (imem_wmask),
        .imem_rdata_i (imem_rdata),
        .imem_sel_o   (imem_sel),
        .core_rst_no  (core_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; bit rd; int lat; int issue; } exp_t;
    typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] m; } mw_t;

    exp_t exp_q[$];
    mw_t  mw_q[$];
    int checks = 0, errors = 0, cyc_cnt = 0;
    logic prev_ack = 1'b0;

    logic [31:0] imem [256];
    logic [31:0] mdl_mem [256];
    bit m_run, m_autoinc, m_wrap, m_err;
    int m_ptr, m_cnt;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instruction memory seen by the DUT.
    always @(posedge clk) begin
        if (imem_en) begin
            if (imem_we) begin
                for (int b = 0; b < 4; b++)
                    if (imem_wmask[b]) imem[imem_addr][8*b +: 8] <= imem_wdata[8*b +: 8];
            end else begin
                imem_rdata <= imem[imem_addr];
            end
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_autoinc = 0; m_wrap = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
    endfunction

    function automatic void model(input logic [7:0] off, input bit w, input logic [31:0] d,
                                  input logic [3:0] s, output logic [31:0] rd, output int lat);
        logic [31:0] bm;
        rd = 32'd0;
        lat = 1;
        case (off)
            8'h00: if (w) begin m_run = d[0]; m_autoinc = d[1]; end
                   else rd = {30'd0, m_autoinc, m_run};
            8'h04: if (w) m_ptr = int'(d[7:0]); else rd = m_ptr;
            8'h08: begin
                if (m_run) begin
                    m_err = 1;
                end else if (w) begin
                    mw_q.push_back('{8'(m_ptr), d, s});
                    for (int b = 0; b < 4; b++) begin
                        bm = 32'hFF << (8 * b);
                        if (s[b]) mdl_mem[m_ptr] = (mdl_mem[m_ptr] & ~bm) | (d & bm);
                    end
                    if (m_cnt < 65535) m_cnt++;
                    if (m_autoinc) begin
                        if (m_ptr == 255) m_wrap = 1;
                        m_ptr = (m_ptr + 1) % 256;
                    end
                    lat = 2;
                end else begin
`ifdef LOADER_READBACK_EN
                    rd = mdl_mem[m_ptr];
                    lat = 3;
`endif
                end
            end
            8'h0C: if (w) begin m_wrap = 0; m_err = 0; m_cnt = 0; end
                   else rd = {m_cnt[15:0], 14'd0, m_err, m_wrap};
            default: ;
        endcase
    endfunction

    always @(negedge clk) prev_ack <= ack;

    always @(negedge clk) begin
        exp_t e;
        mw_t  m;
        if (rst_n) begin
            if (ack && prev_ack) begin
                checks++; errors++;
                $display("FAIL ack_twice: ack high two consecutive cycles, required single cycle");
            end
            if (ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    check("ack_latency", 32'(cyc_cnt - e.issue), 32'(e.lat));
                    if (e.rd) check("read_data", rdat, e.data);
                end
            end
            if (imem_en && imem_we) begin
                if (mw_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_write: got write at %h, required none", imem_addr);
                end else begin
                    m = mw_q.pop_front();
                    check("mem_addr", 32'(imem_addr), 32'(m.a));
                    check("mem_wdata", imem_wdata, m.d);
                    check("mem_wmask", 32'(imem_wmask), 32'(m.m));
                end
            end
`ifndef LOADER_READBACK_EN
            if (imem_en && !imem_we) begin
                checks++; errors++;
                $display("FAIL mem_read_strobe: got read strobe, required none");
            end
`endif
        end
    end

    task automatic xfer(input logic [7:0] off, input bit w, input logic [31:0] d,
                        input logic [3:0] s);
        exp_t e;
        logic [31:0] rd;
        int lat;
        bit got = 0;
        @(posedge clk); #1;
        model(off, w, d, s, rd, lat);
        e.data = rd; e.rd = !w; e.lat = lat; e.issue = cyc_cnt;
        exp_q.push_back(e);
        adr = BASE | 32'(off); we = w; wdat = d; sel = s; stb = 1; cyc = 1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        stb = 0; cyc = 0; we = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout off=%h: got no ack, required ack within 20 cycles", off);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    // Drives a request that must never be acked: cyc dropped after one cycle, or outside the window.
    task automatic no_ack_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                               input int hold, input string name);
        int acks = 0;
        @(posedge clk); #1;
        adr = a; we = w; wdat = d; sel = 4'hF; stb = 1; cyc = 1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 0; cyc = 0; we = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check(name, 32'(acks), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_dummy;
        int lat_dummy, r;
        logic [7:0] off;
        for (int i = 0; i < 256; i++) begin
            imem[i] = $urandom;
            mdl_mem[i] = imem[i];
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_imem_sel", 32'(imem_sel), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        @(negedge clk); rst_n = 1;

        xfer(8'h00, 0, 0, 4'hF);
        xfer(8'h04, 0, 0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);

        xfer(8'h00, 1, 32'h2, 4'hF);
        xfer(8'h04, 1, 32'h10, 4'hF);
        xfer(8'h08, 1, 32'hDEADBEEF, 4'hF);
        xfer(8'h08, 1, 32'h12345678, 4'hF);
        xfer(8'h04, 0, 0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);

        xfer(8'h04, 1, 32'hFF, 4'hF);
        xfer(8'h08, 1, 32'hCAFEF00D, 4'hF);
        xfer(8'h04, 0, 0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);
        xfer(8'h0C, 1, 32'h0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);

        xfer(8'h04, 1, 32'h10, 4'hF);
        xfer(8'h08, 0, 0, 4'hF);

        // Write abandoned in MWR still lands and advances the pointer.
        model(8'h08, 1, 32'hA5A5_0001, 4'hF, rd_dummy, lat_dummy);
        no_ack_xfer(BASE | 32'h8, 1, 32'hA5A5_0001, 1, "drop_mwr_noack");
`ifdef LOADER_READBACK_EN
        no_ack_xfer(BASE | 32'h8, 0, 0, 1, "drop_mrd_noack");
`endif
        xfer(8'h04, 0, 0, 4'hF);
        xfer(8'h08, 0, 0, 4'hF);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1: xfer(8'h00, 1, {30'd0, 1'($urandom), 1'b0}, 4'hF);
                2, 3: xfer(8'h04, 1, ($urandom_range(0, 2) == 0) ? 32'hFC + $urandom_range(0, 3)
                                                                    : $urandom, 4'hF);
                4, 5, 6, 7, 8: xfer(8'h08, 1, $urandom, 4'($urandom));
                9, 10: xfer(8'h08, 0, 0, 4'hF);
                11: xfer(8'($urandom_range(0, 1) * 4), 0, 0, 4'hF);
                12: xfer(8'h0C, 1, $urandom, 4'hF);
                13: begin
                    off = 8'($urandom_range(1, 255));
                    if (off == 8'h04 || off == 8'h08 || off == 8'h0C) off = 8'h10;
                    xfer(off, 1'($urandom), $urandom, 4'hF);
                end
                14: no_ack_xfer(BASE ^ (32'h100 << $urandom_range(0, 23)), 1'($urandom),
                                $urandom, 3, "out_of_window_noack");
                default: xfer(8'h0C, 0, 0, 4'hF);
            endcase
        end

        xfer(8'h00, 1, 32'h1, 4'hF);
        check("ctrl_ack_cycle_core_rst_n", 32'(core_rst_n), 32'd0);
        @(posedge clk); #1;
        check("run_core_rst_n", 32'(core_rst_n), 32'd1);
        check("run_imem_sel", 32'(imem_sel), 32'd0);
        xfer(8'h08, 1, 32'h5555AAAA, 4'hF);
        xfer(8'h08, 0, 0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);
        xfer(8'h00, 1, 32'h0, 4'hF);

        // Reset while the write strobe is out.
        @(posedge clk); #1;
        adr = BASE | 32'h8; we = 1; wdat = 32'h0BAD_0BAD; sel = 4'hF; stb = 1; cyc = 1;
        @(posedge clk); #1;
        check("mwr_strobe", 32'(imem_en), 32'd1);
        rst_n = 0;
        #1;
        check("rst_mid_imem_en", 32'(imem_en), 32'd0);
        check("rst_mid_imem_we", 32'(imem_we), 32'd0);
        check("rst_mid_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_mid_imem_wdata", imem_wdata, 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        check("rst_mid_imem_sel", 32'(imem_sel), 32'd1);
        stb = 0; cyc = 0; we = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        xfer(8'h00, 0, 0, 4'hF);
        xfer(8'h04, 0, 0, 4'hF);
        xfer(8'h0C, 0, 0, 4'hF);
        xfer(8'h08, 0, 0, 4'hF);

        repeat (3) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mw_q_drained", 32'(mw_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
